// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle RISC-V core: opcode constants used by
// the control FSM and datapath, PC-source encodings and immediate formats.
package mc_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Team opcode map; OP_BRANCH intentionally differs from the base ISA encoding.
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100111;

    localparam logic PCSRC_ALU    = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_I    = 2'd1,
        IMM_S    = 2'd2,
        IMM_B    = 2'd3
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
        case (op)
            OP_LOAD,
            OP_IMM:    return IMM_I;
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            default:   return IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mc_imm_gen.sv
// Combinational immediate generator: selects the I/S/B field layout from the
// opcode and sign-extends to XLEN. Unknown opcodes and R-type yield zero.
module mc_imm_gen
    import mc_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    imm_fmt_e    fmt;
    logic [31:0] imm32;

    assign fmt = imm_fmt(instr[6:0]);

    // NOTE: imm32 gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        imm32 = 32'h0000_0000;
        case (fmt)
            IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            default: imm32 = 32'h0000_0000;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/mc_fetch_regs.sv
// PC, IR, MDR and ALUOut register bank of the multicycle core, with IR decode,
// memory address mux, sticky PC-misalignment flag and instruction-fetch counter.
module mc_fetch_regs
    import mc_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IRWrite,
    input  logic             PCWrite,
    input  logic             PCWriteCond,
    input  logic             PCSource,
    input  logic             IorD,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_zero,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  mem_addr,
    output logic [31:0]      instr,
    output logic [XLEN-1:0]  mdr,
    output logic [XLEN-1:0]  alu_out,
    output logic [6:0]       opcode,
    output logic [4:0]       rd,
    output logic [2:0]       funct3,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [6:0]       funct7,
    output logic [XLEN-1:0]  imm,
    output logic             pc_misaligned,
    output logic [CNT_W-1:0] fetch_count
);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [XLEN-1:0]  mdr_q, mdr_d;
    logic [XLEN-1:0]  alu_out_q, alu_out_d;
    logic             misaligned_q, misaligned_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

    logic             pc_en;
    logic [XLEN-1:0]  next_pc;

    always_comb begin
        pc_en   = PCWrite | (PCWriteCond & alu_zero);
        next_pc = (PCSource == PCSRC_ALUOUT) ? alu_out_q : alu_result;

        pc_d          = pc_en ? next_pc : pc_q;
        // The misaligned target is still loaded; only the flag records it.
        misaligned_d  = misaligned_q | (pc_en & (next_pc[1:0] != 2'b00));
        instr_d       = IRWrite ? mem_rdata[31:0] : instr_q;
        fetch_count_d = IRWrite ? fetch_count_q + CNT_W'(1) : fetch_count_q;
        mdr_d         = mem_rdata;
        alu_out_d     = alu_result;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; this is what lets IR capture data addressed by the old PC
    // while PC advances on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0000_0000;
            mdr_q         <= '0;
            alu_out_q     <= '0;
            misaligned_q  <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            mdr_q         <= mdr_d;
            alu_out_q     <= alu_out_d;
            misaligned_q  <= misaligned_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Address mux is driven only by registered state, never by mem_rdata.
    assign mem_addr = IorD ? alu_out_q : pc_q;

    assign pc            = pc_q;
    assign instr         = instr_q;
    assign mdr           = mdr_q;
    assign alu_out       = alu_out_q;
    assign pc_misaligned = misaligned_q;
    assign fetch_count   = fetch_count_q;

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign funct3 = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign funct7 = instr_q[31:25];

    mc_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (instr_q),
        .imm   (imm)
    );

endmodule
